// File: rtl/fc_argmax_stage.sv
// rtl/fc_argmax_stage.sv - running argmax over each M-result vector from the FC layer
//
// Purpose: consumes M signed results per vector, in row order, and emits one
// {index, value} pair per vector: the row holding the largest value.
// When several rows hold the same largest value, the lowest row index wins.
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   input_valid/ready/data     result stream from the FC layer (valid/ready)
//   output_valid/ready         handshake for the winning {index, value}
//   output_index, output_value winning row index and its signed value
//   frame_count                results emitted since reset (wraps)
module fc_argmax_stage #(
  parameter int WIDTH = 16,
  parameter int M     = 8,
  parameter int CNTW  = 16,
  localparam int IDXW = ($clog2(M) > 1) ? $clog2(M) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             input_valid,
  output logic             input_ready,
  input  logic [WIDTH-1:0] input_data,
  output logic             output_valid,
  input  logic             output_ready,
  output logic [IDXW-1:0]  output_index,
  output logic [WIDTH-1:0] output_value,
  output logic [CNTW-1:0]  frame_count
);

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_EMIT    = 1'b1;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(M - 1);

  logic [0:0]       state;
  logic [IDXW-1:0]  elem_cnt;
  logic [WIDTH-1:0] max_val;
  logic [IDXW-1:0]  max_idx;

  logic             in_xfer;
  logic             out_xfer;
  logic             take_new;
  logic [WIDTH-1:0] next_val;
  logic [IDXW-1:0]  next_idx;

  // Ready depends only on state, so upstream never sees a combinational
  // path from its own valid.
  assign input_ready = (state == ST_COLLECT);
  assign in_xfer     = input_valid & input_ready;
  assign out_xfer    = output_valid & output_ready;

  // The first element of a vector always seeds the max; afterwards only a
  // strictly greater value replaces it, which gives lowest-index-wins on ties.
  always_comb begin
    take_new = (elem_cnt == '0) || ($signed(input_data) > $signed(max_val));
    next_val = take_new ? input_data : max_val;
    next_idx = take_new ? elem_cnt : max_idx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_COLLECT;
      elem_cnt     <= '0;
      max_val      <= '0;
      max_idx      <= '0;
      output_valid <= 1'b0;
      output_index <= '0;
      output_value <= '0;
      frame_count  <= '0;
    end else begin
      case (state)
        ST_COLLECT: begin
          if (in_xfer) begin
            max_val <= next_val;
            max_idx <= next_idx;
            if (elem_cnt == LAST_IDX) begin
              // The last element is folded in here, so the final result
              // is ready one cycle after the M-th transfer.
              output_value <= next_val;
              output_index <= next_idx;
              output_valid <= 1'b1;
              elem_cnt     <= '0;
              state        <= ST_EMIT;
            end else begin
              elem_cnt <= elem_cnt + 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (out_xfer) begin
            output_valid <= 1'b0;
            frame_count  <= frame_count + 1'b1;
            state        <= ST_COLLECT;
          end
        end
        default: begin
          state        <= ST_COLLECT;
          elem_cnt     <= '0;
          output_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_argmax_stage.sv
// tb/tb_fc_argmax_stage.sv - self-checking bench for fc_argmax_stage
module tb_fc_argmax_stage;

  localparam int WIDTH = 16;
  localparam int M     = 8;
  localparam int CNTW  = 16;
  localparam int IDXW  = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             input_valid;
  logic             input_ready;
  logic [WIDTH-1:0] input_data;
  logic             output_valid;
  logic             output_ready;
  logic [IDXW-1:0]  output_index;
  logic [WIDTH-1:0] output_value;
  logic [CNTW-1:0]  frame_count;

  fc_argmax_stage #(.WIDTH(WIDTH), .M(M), .CNTW(CNTW)) dut (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_index (output_index),
    .output_value (output_value),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int vals [8];
    int idx;
    int val;
  } vec_t;

  vec_t tab [5];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Streams one vector; with rnd set, idle cycles are inserted before elements.
  task automatic send_vector(input int v [8], input bit rnd);
    for (int i = 0; i < M; i++) begin
      if (rnd) begin
        for (int g = 0; g < 3; g++) begin
          if ($urandom_range(1, 0) == 1) begin
            input_valid = 1'b0;
            tick();
          end
        end
      end
      input_valid = 1'b1;
      input_data  = WIDTH'(v[i]);
      for (int n = 0; n < 50 && !input_ready; n++) tick();
      if (!input_ready) check("ready_timeout", 0, 1);
      if (i == M - 1) check("valid_before_last", int'(output_valid), 0);
      tick();
    end
    input_valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input int e_idx, input int e_val);
    check({tag, "_valid"}, int'(output_valid), 1);
    check({tag, "_index"}, int'(output_index), e_idx);
    check({tag, "_value"}, int'($signed(output_value)), e_val);
    check({tag, "_ready_low"}, int'(input_ready), 0);
  endtask

  initial begin
    int saved_idx;
    int saved_val;
    tab[0].vals = '{3, -5, 7, 2, 7, 0, -1, 6};
    tab[0].idx = 2;  tab[0].val = 7;
    tab[1].vals = '{-9, -3, -32768, -3, -4, -100, -7, -8};
    tab[1].idx = 1;  tab[1].val = -3;
    tab[2].vals = '{0, 0, 0, 0, 0, 0, 0, 0};
    tab[2].idx = 0;  tab[2].val = 0;
    tab[3].vals = '{0, 0, 0, 0, 0, 0, 0, 32767};
    tab[3].idx = 7;  tab[3].val = 32767;
    tab[4].vals = '{1, 2, 3, 4, 5, 6, 7, 8};
    tab[4].idx = 7;  tab[4].val = 8;

    input_valid  = 1'b0;
    input_data   = '0;
    output_ready = 1'b1;
    do_reset();

    check("rst_ready", int'(input_ready), 1);
    check("rst_valid", int'(output_valid), 0);
    check("rst_index", int'(output_index), 0);
    check("rst_value", int'(output_value), 0);
    check("rst_frames", int'(frame_count), 0);

    // back-to-back vectors with output_ready held high
    for (int t = 0; t < 5; t++) begin
      send_vector(tab[t].vals, 1'b0);
      check_result($sformatf("vec%0d", t), tab[t].idx, tab[t].val);
      tick();
      check($sformatf("vec%0d_consumed", t), int'(output_valid), 0);
      check($sformatf("vec%0d_frames", t), int'(frame_count), t + 1);
    end

    // long EMIT stall with upstream pushing
    do_reset();
    output_ready = 1'b0;
    send_vector(tab[0].vals, 1'b0);
    check_result("stall", 2, 7);
    input_valid = 1'b1;
    input_data  = WIDTH'(99);
    saved_idx = int'(output_index);
    saved_val = int'($signed(output_value));
    for (int c = 0; c < 20; c++) begin
      tick();
      check("stall_ready", int'(input_ready), 0);
      check("stall_valid", int'(output_valid), 1);
      check("stall_index", int'(output_index), saved_idx);
      check("stall_value", int'($signed(output_value)), saved_val);
    end
    check("stall_frames", int'(frame_count), 0);
    input_valid  = 1'b0;
    output_ready = 1'b1;
    tick();
    check("stall_release", int'(output_valid), 0);
    check("stall_frames1", int'(frame_count), 1);
    send_vector(tab[3].vals, 1'b0);
    check_result("after_stall", 7, 32767);
    tick();
    check("after_stall_frames", int'(frame_count), 2);

    // random input_valid gaps across three vectors
    do_reset();
    send_vector(tab[0].vals, 1'b1);
    check_result("rnd0", 2, 7);
    tick();
    send_vector(tab[1].vals, 1'b1);
    check_result("rnd1", 1, -3);
    tick();
    send_vector(tab[4].vals, 1'b1);
    check_result("rnd2", 7, 8);
    tick();
    check("rnd_frames", int'(frame_count), 3);

    // reset in the middle of a vector
    for (int i = 0; i < 4; i++) begin
      input_valid = 1'b1;
      input_data  = WIDTH'(100 + i);
      tick();
    end
    input_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_index", int'(output_index), 0);
    check("midrst_value", int'(output_value), 0);
    check("midrst_valid", int'(output_valid), 0);
    check("midrst_frames", int'(frame_count), 0);
    check("midrst_elem_cnt", int'(dut.elem_cnt), 0);
    check("midrst_ready", int'(input_ready), 1);
    send_vector(tab[4].vals, 1'b0);
    check_result("midrst_vec", 7, 8);
    tick();
    check("midrst_vec_frames", int'(frame_count), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
